stream_mux_arb: RTL and testbench

//  Parametrised N:1, W-bit registered stream multiplexer with valid/ready handshake and per-packet channel lock.
//  Two modes: the external select chooses the source, or a built-in round-robin arbiter chooses it.

---
 rtl/stream_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/stream_mux_arb.sv | 105 ++++++++++
 tb/tb_stream_mux_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package stream_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width needed to address n channels (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester above ptr, wrapping modulo N.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 registered stream mux with valid/ready flow control, per-packet channel lock,
// and either external select or round-robin source choice.
module stream_mux_arb
  import stream_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SW   = idx_w(N),
  parameter int MODE = MODE_SEL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready,
  output logic           locked
);

  logic [W-1:0]  data_p1;
  logic          last_p1;
  logic [SW-1:0] src_p1;
  logic          vld_p1;

  logic          lock_q;
  logic [SW-1:0] lock_idx_q;
  logic [SW-1:0] ptr_q;

  logic [SW-1:0] rr_idx;
  logic          rr_vld;
  logic [SW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          slot_free;
  logic          accept;
  logic          acc_last;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // A held lock overrides both select sources; out-of-range sel grants nobody.
  always_comb begin
    if (lock_q) begin
      gnt_idx = lock_idx_q;
      gnt_vld = 1'b1;
    end else if (MODE == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt_idx = sel;
      gnt_vld = ({1'b0, sel} < (SW+1)'(N));
    end
  end

  assign slot_free = !vld_p1 || out_ready;

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < N; c++)
      in_ready[c] = !rst && slot_free && gnt_vld && (gnt_idx == SW'(c));
  end

  assign accept   = |(in_valid & in_ready);
  assign acc_last = in_last[gnt_idx];

  // ---- stage p0 -> p1: output register, lock and packet-fair pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1    <= '0;
      last_p1    <= 1'b0;
      src_p1     <= '0;
      vld_p1     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= SW'(N-1);
    end else if (accept) begin
      data_p1    <= in_data[gnt_idx*W +: W];
      last_p1    <= acc_last;
      src_p1     <= gnt_idx;
      vld_p1     <= 1'b1;
      lock_q     <= !acc_last;
      lock_idx_q <= gnt_idx;
      if (acc_last)
        ptr_q <= gnt_idx;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_src   = src_p1;
  assign out_valid = vld_p1;
  assign locked    = lock_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench: three instances (select N=4, round-robin N=4, select N=3) on one clock.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: MODE 0, N=4
  logic [127:0] a_data;
  logic [3:0]   a_valid, a_last, a_ready;
  logic [1:0]   a_sel, a_src;
  logic [31:0]  a_odata;
  logic         a_ovalid, a_olast, a_oready, a_locked;
  // instance b: MODE 1, N=4
  logic [127:0] b_data;
  logic [3:0]   b_valid, b_last, b_ready;
  logic [1:0]   b_sel, b_src;
  logic [31:0]  b_odata;
  logic         b_ovalid, b_olast, b_oready, b_locked;
  // instance c: MODE 0, N=3
  logic [95:0]  c_data;
  logic [2:0]   c_valid, c_last, c_ready;
  logic [1:0]   c_sel, c_src;
  logic [31:0]  c_odata;
  logic         c_ovalid, c_olast, c_oready, c_locked;

  stream_mux_arb #(.W(32), .N(4), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(a_ready), .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid),
    .out_last(a_olast), .out_src(a_src), .out_ready(a_oready), .locked(a_locked));

  stream_mux_arb #(.W(32), .N(4), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid),
    .out_last(b_olast), .out_src(b_src), .out_ready(b_oready), .locked(b_locked));

  stream_mux_arb #(.W(32), .N(3), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
    .in_ready(c_ready), .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid),
    .out_last(c_olast), .out_src(c_src), .out_ready(c_oready), .locked(c_locked));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = '1; a_last = '1; a_sel = 2'd0; a_oready = 1'b1;
    b_data = '0; b_valid = '1; b_last = '1; b_sel = 2'd0; b_oready = 1'b1;
    c_data = '0; c_valid = '1; c_last = '1; c_sel = 2'd0; c_oready = 1'b1;

    // 1. reset held two cycles with every channel valid
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_a_ovalid", 32'(a_ovalid), 32'd0);
      chk("rst_a_ready",  32'(a_ready),  32'd0);
      chk("rst_a_src",    32'(a_src),    32'd0);
      chk("rst_a_locked", 32'(a_locked), 32'd0);
      chk("rst_b_ovalid", 32'(b_ovalid), 32'd0);
      chk("rst_b_ready",  32'(b_ready),  32'd0);
      chk("rst_c_ovalid", 32'(c_ovalid), 32'd0);
      chk("rst_c_locked", 32'(c_locked), 32'd0);
    end
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_last = '0; b_last = '0; c_last = '0;
    #1 rst = 1'b0;
    step();

    // 2. MODE 0 packet on ch2, sel moves to 1 mid-packet
    a_sel = 2'd2;
    a_valid = 4'b0110;
    a_data[2*32 +: 32] = 32'hA0; a_last[2] = 1'b0;
    a_data[1*32 +: 32] = 32'hB1; a_last[1] = 1'b1;
    #1 chk("m0_ready_pre", 32'(a_ready), 32'h4);
    step();
    chk("m0_data0", a_odata, 32'hA0);
    chk("m0_src0", 32'(a_src), 32'd2);
    chk("m0_lock0", 32'(a_locked), 32'd1);
    a_data[2*32 +: 32] = 32'hA1; a_sel = 2'd1;
    #1 chk("m0_ready_locked", 32'(a_ready), 32'h4);
    step();
    chk("m0_data1", a_odata, 32'hA1);
    chk("m0_lock1", 32'(a_locked), 32'd1);
    a_data[2*32 +: 32] = 32'hA2; a_last[2] = 1'b1;
    step();
    chk("m0_data2", a_odata, 32'hA2);
    chk("m0_last2", 32'(a_olast), 32'd1);
    chk("m0_src2", 32'(a_src), 32'd2);
    chk("m0_lock2", 32'(a_locked), 32'd0);
    a_valid = 4'b0010;
    #1 chk("m0_ready_ch1", 32'(a_ready), 32'h2);
    step();
    chk("m0_data_b1", a_odata, 32'hB1);
    chk("m0_src_b1", 32'(a_src), 32'd1);
    a_valid = '0;
    step();
    chk("m0_drain", 32'(a_ovalid), 32'd0);

    // 4. backpressure on instance a
    a_sel = 2'd0; a_valid = 4'b0001; a_last = 4'b0001;
    a_data[0 +: 32] = 32'hC0;
    step();
    chk("bp_data0", a_odata, 32'hC0);
    a_data[0 +: 32] = 32'hC1; a_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_stall", 32'(a_ready), 32'd0);
      step();
      chk("bp_hold_data", a_odata, 32'hC0);
      chk("bp_hold_valid", 32'(a_ovalid), 32'd1);
    end
    a_oready = 1'b1;
    #1 chk("bp_ready_resume", 32'(a_ready), 32'h1);
    step();
    chk("bp_data1", a_odata, 32'hC1);
    chk("bp_valid1", 32'(a_ovalid), 32'd1);
    a_valid = '0;
    step();
    chk("bp_drain", 32'(a_ovalid), 32'd0);

    // 3. round-robin over single-beat packets on all four channels
    b_valid = 4'b1111; b_last = 4'b1111;
    for (int c = 0; c < 4; c++) b_data[c*32 +: 32] = 32'hD0 + 32'(c);
    #1 chk("rr_ready_first", 32'(b_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_src", 32'(b_src), 32'(i % 4));
      chk("rr_data", b_odata, 32'hD0 + 32'(i % 4));
    end
    b_valid = '0;
    step();
    chk("rr_drain", 32'(b_ovalid), 32'd0);

    // 5. lock on ch1 in round-robin mode (pointer now 1)
    b_valid = 4'b0010; b_last = 4'b0000;
    b_data[1*32 +: 32] = 32'hE0;
    step();
    chk("rrl_src0", 32'(b_src), 32'd1);
    chk("rrl_lock0", 32'(b_locked), 32'd1);
    b_valid = 4'b1011; b_last = 4'b1001;
    b_data[0 +: 32] = 32'hF0; b_data[3*32 +: 32] = 32'hF3;
    b_data[1*32 +: 32] = 32'hE1;
    #1 chk("rrl_ready_locked", 32'(b_ready), 32'h2);
    step();
    chk("rrl_src1", 32'(b_src), 32'd1);
    chk("rrl_data1", b_odata, 32'hE1);
    b_data[1*32 +: 32] = 32'hE2; b_last[1] = 1'b1;
    step();
    chk("rrl_data2", b_odata, 32'hE2);
    chk("rrl_unlock", 32'(b_locked), 32'd0);
    b_valid = 4'b1001;
    #1 chk("rrl_ready_next", 32'(b_ready), 32'h8);
    step();
    chk("rrl_src_next", 32'(b_src), 32'd3);
    chk("rrl_data_next", b_odata, 32'hF3);
    b_valid = '0;
    step();

    // 6. N=3: out-of-range select, then reset during a locked packet
    c_sel = 2'd3; c_valid = 3'b111; c_last = 3'b000;
    #1 chk("n3_ready_none", 32'(c_ready), 32'd0);
    step();
    chk("n3_ovalid0", 32'(c_ovalid), 32'd0);
    step();
    chk("n3_ovalid1", 32'(c_ovalid), 32'd0);
    c_sel = 2'd0; c_data[0 +: 32] = 32'h55;
    step();
    chk("n3_lock_set", 32'(c_locked), 32'd1);
    chk("n3_data", c_odata, 32'h55);
    rst = 1'b1;
    step();
    chk("n3_rst_lock", 32'(c_locked), 32'd0);
    chk("n3_rst_ovalid", 32'(c_ovalid), 32'd0);
    rst = 1'b0;
    c_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
